// File: rtl/tl_pkg.sv
// Shared encodings for the traffic-light sequencer: controller states,
// lamp codes and a small sizing helper.
package tl_pkg;

  typedef enum logic [1:0] {
    S_A_GREEN  = 2'b00,
    S_A_YELLOW = 2'b01,
    S_B_GREEN  = 2'b10,
    S_B_YELLOW = 2'b11
  } state_t;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Saturating cycle counter: counts cycles spent in the current phase,
// cleared synchronously on a phase change, holds at SAT.
module tl_phase_timer #(
  parameter int W   = 4,
  parameter int SAT = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] SAT_VAL = W'(SAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (cnt != SAT_VAL)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tl_sched_cntr.sv
// Timed two-street traffic-light sequencer with min/max green and fixed yellow.
// Define TL_ALL_RED_EN to insert an all-red CLEAR interval after each yellow.
module tl_sched_cntr
  import tl_pkg::*;
#(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 8,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [1:0] phase,
  output logic       switch_pulse
);

  localparam int CNT_TOP = max3(MAX_GREEN, YELLOW_TIME, ALL_RED_TIME);
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_TIME - 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          clear_cnt;
  logic          enter_green;

`ifdef TL_ALL_RED_EN
  localparam logic [CW-1:0] CLR_LAST = CW'(ALL_RED_TIME - 1);

  // CLEAR is held in the yellow state encoding so phase keeps the yellow code.
  logic in_clear;
  logic next_in_clear;
  logic dir;
  logic next_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_clear <= 1'b0;
      dir      <= 1'b0;
    end else begin
      in_clear <= next_in_clear;
      dir      <= next_dir;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_A_GREEN;
      switch_pulse <= 1'b0;
    end else begin
      state        <= next_state;
      switch_pulse <= enter_green;
    end
  end

  always_comb begin
    next_state  = state;
    enter_green = 1'b0;
`ifdef TL_ALL_RED_EN
    next_in_clear = in_clear;
    next_dir      = dir;
`endif
    case (state)
      S_A_GREEN:
        if (cnt >= MIN_LAST && (!Ta || (Tb && cnt >= MAX_LAST)))
          next_state = S_A_YELLOW;
      S_B_GREEN:
        if (cnt >= MIN_LAST && (!Tb || (Ta && cnt >= MAX_LAST)))
          next_state = S_B_YELLOW;
      default: begin
`ifdef TL_ALL_RED_EN
        if (in_clear) begin
          if (cnt == CLR_LAST) begin
            next_in_clear = 1'b0;
            next_state    = dir ? S_B_GREEN : S_A_GREEN;
            enter_green   = 1'b1;
          end
        end else if (cnt == YEL_LAST) begin
          next_in_clear = 1'b1;
          next_dir      = (state == S_A_YELLOW);
        end
`else
        if (cnt == YEL_LAST) begin
          next_state  = (state == S_A_YELLOW) ? S_B_GREEN : S_A_GREEN;
          enter_green = 1'b1;
        end
`endif
      end
    endcase
`ifdef TL_ALL_RED_EN
    clear_cnt = (next_state != state) || (next_in_clear != in_clear);
`else
    clear_cnt = (next_state != state);
`endif
  end

  always_comb begin
    La = L_RED;
    Lb = L_RED;
    case (state)
      S_A_GREEN:  La = L_GREEN;
      S_A_YELLOW: La = L_YELLOW;
      S_B_GREEN:  Lb = L_GREEN;
      default:    Lb = L_YELLOW;
    endcase
`ifdef TL_ALL_RED_EN
    if (in_clear) begin
      La = L_RED;
      Lb = L_RED;
    end
`endif
  end

  assign phase = state;

  tl_phase_timer #(
    .W   (CW),
    .SAT (CNT_TOP - 1)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear_cnt),
    .cnt   (cnt)
  );

endmodule

// File: tb/tb_tl_sched_cntr.sv
// Directed bench for tl_sched_cntr (MIN_GREEN=4, MAX_GREEN=8, YELLOW_TIME=2).
// Outputs are sampled on the falling clock edge; cycle 0 is the one at reset release.
module tb_tl_sched_cntr;

  logic       clk;
  logic       reset;
  logic       Ta;
  logic       Tb;
  logic [1:0] La;
  logic [1:0] Lb;
  logic [1:0] phase;
  logic       switch_pulse;

  int compared;
  int mismatched;

  tl_sched_cntr #(
    .MIN_GREEN    (4),
    .MAX_GREEN    (8),
    .YELLOW_TIME  (2),
    .ALL_RED_TIME (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Ta           (Ta),
    .Tb           (Tb),
    .La           (La),
    .Lb           (Lb),
    .phase        (phase),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ta, input logic tb);
    Ta = ta;
    Tb = tb;
  endtask

  // Hold reset over one rising edge, release on a falling edge (cycle 0).
  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [1:0] expLa(input logic [1:0] ph);
    case (ph)
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] expLb(input logic [1:0] ph);
    case (ph)
      2'b10:   return 2'b00;
      2'b11:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic checkPhase(input string tag, input logic [1:0] ph);
    checkOutput({tag, "_phase"}, 32'(phase), 32'(ph));
    checkOutput({tag, "_La"}, 32'(La), 32'(expLa(ph)));
    checkOutput({tag, "_Lb"}, 32'(Lb), 32'(expLb(ph)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] ph;
    logic       sp;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #2;
    checkPhase("rst_async", 2'b00);
    checkOutput("rst_pulse", 32'(switch_pulse), 32'd0);

    // Scenario 1: own traffic only, A_GREEN held indefinitely.
    applyStimulus(1'b1, 1'b0);
    doReset();
    for (int k = 0; k < 20; k++) begin
      checkPhase("hold_a", 2'b00);
      checkOutput("hold_a_pulse", 32'(switch_pulse), 32'd0);
      @(negedge clk);
    end

    // Scenario 2: cross traffic only, 4 green + 2 yellow then B_GREEN.
    applyStimulus(1'b0, 1'b1);
    doReset();
    for (int k = 0; k < 10; k++) begin
`ifdef TL_ALL_RED_EN
      ph = (k < 4) ? 2'b00 : (k < 7) ? 2'b01 : 2'b10;
      sp = (k == 7);
      if (k == 6) begin
        checkOutput("clear_phase", 32'(phase), 32'(2'b01));
        checkOutput("clear_La", 32'(La), 32'(2'b10));
        checkOutput("clear_Lb", 32'(Lb), 32'(2'b10));
      end else
        checkPhase("to_b", ph);
`else
      ph = (k < 4) ? 2'b00 : (k < 6) ? 2'b01 : 2'b10;
      sp = (k == 6);
      checkPhase("to_b", ph);
`endif
      checkOutput("to_b_pulse", 32'(switch_pulse), 32'(sp));
      @(negedge clk);
    end

    // Scenario 4: async reset pulse in the middle of A_YELLOW.
    applyStimulus(1'b0, 1'b1);
    doReset();
    repeat (4) @(negedge clk);
    checkPhase("pre_rst_yellow", 2'b01);
    #1 reset = 1'b1;
    #1;
    checkPhase("mid_rst", 2'b00);
    checkOutput("mid_rst_pulse", 32'(switch_pulse), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkPhase("post_rst", (k < 4) ? 2'b00 : 2'b01);
    end

`ifndef TL_ALL_RED_EN
    // Scenario 3: both waiting, max-green fairness, period 20.
    applyStimulus(1'b1, 1'b1);
    doReset();
    for (int k = 0; k < 42; k++) begin
      int m;
      m  = k % 20;
      ph = (m < 8) ? 2'b00 : (m < 10) ? 2'b01 : (m < 18) ? 2'b10 : 2'b11;
      sp = (m == 10) || (m == 0 && k != 0);
      checkPhase("fair", ph);
      checkOutput("fair_pulse", 32'(switch_pulse), 32'(sp));
      @(negedge clk);
    end

    // Scenario 5: idle rotation 4/2/4/2, lamps never both non-red.
    applyStimulus(1'b0, 1'b0);
    doReset();
    for (int k = 0; k < 26; k++) begin
      int m;
      m  = k % 12;
      ph = (m < 4) ? 2'b00 : (m < 6) ? 2'b01 : (m < 10) ? 2'b10 : 2'b11;
      checkPhase("idle", ph);
      checkOutput("idle_exclusive", 32'((La != 2'b10) && (Lb != 2'b10)), 32'd0);
      @(negedge clk);
    end
`endif

    // Mid-green sensor change: B_GREEN released once Tb drops after min green.
    applyStimulus(1'b0, 1'b1);
    doReset();
`ifdef TL_ALL_RED_EN
    repeat (7) @(negedge clk);
`else
    repeat (6) @(negedge clk);
`endif
    checkPhase("b_green_entry", 2'b10);
    applyStimulus(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkPhase("b_green_held", 2'b10);
    @(negedge clk);
    checkPhase("b_yellow", 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tl_sched_cntr.md
Name: tl_sched_cntr

Overview:
- Timed traffic-light sequencer for a two-street intersection (street A, street B), driven by the car sensors Ta/Tb.
- Extends the basic 4-state light FSM with three timing rules: a minimum green time, a maximum green time for fairness, and a fixed yellow duration.
- Top-level light controller; drives the La/Lb lamp codes and exposes the current phase for display/debug.

Parameters:
MIN_GREEN, 4, minimum cycles a green phase is held (>=1)
MAX_GREEN, 8, maximum cycles a green is held while the cross street is waiting (>=MIN_GREEN)
YELLOW_TIME, 2, exact cycles of each yellow phase (>=1)
ALL_RED_TIME, 1, all-red clearance cycles; used only with TL_ALL_RED_EN (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Ta  input  1  car present on street A
Tb  input  1  car present on street B
La  output  2  street A lamp: 00 green, 01 yellow, 10 red
Lb  output  2  street B lamp, same coding
phase  output  2  current state: 00 A_GREEN, 01 A_YELLOW, 10 B_GREEN, 11 B_YELLOW
switch_pulse  output  1  high for exactly one cycle, on the first cycle of each green phase

Behaviour:
- Reset (async, active-high):
  - state=A_GREEN, cnt=0, La=00, Lb=10, phase=00, switch_pulse=0.
  - Takes effect immediately, without a clock edge, and from any state including mid-yellow.
- cnt holds the number of cycles already spent in the current state.
  - Cleared to 0 on every state transition; otherwise increments each cycle.
  - Saturates at MAX_GREEN-1.
  - Width: $clog2(max(MAX_GREEN,YELLOW_TIME,ALL_RED_TIME)+1).
- All transitions happen on the rising edge of clk. La, Lb and phase are Moore outputs decoded from the state register, with no extra latency.
- A_GREEN -> A_YELLOW when cnt>=MIN_GREEN-1 AND (Ta==0 OR (Tb==1 AND cnt>=MAX_GREEN-1)).
  - Otherwise the state stays A_GREEN.
  - Ta=0 with Tb=0 still switches after MIN_GREEN cycles (idle rotation).
- A_YELLOW -> B_GREEN when cnt==YELLOW_TIME-1, regardless of the sensors.
- B_GREEN -> B_YELLOW: same rule as A_GREEN with Ta and Tb swapped.
- B_YELLOW -> A_GREEN when cnt==YELLOW_TIME-1.
- Resulting phase lengths:
  - Green lasts at least MIN_GREEN cycles, and at most MAX_GREEN cycles while the cross street is waiting.
  - A green with no cross traffic and its own sensor high is held indefinitely.
  - Yellow lasts exactly YELLOW_TIME cycles.
- Lamp decode per state:
  - A_GREEN: La=00, Lb=10.
  - A_YELLOW: La=01, Lb=10.
  - B_GREEN: La=10, Lb=00.
  - B_YELLOW: La=10, Lb=01.
  - La and Lb are never both non-red.
- switch_pulse is registered: 1 in the first cycle after entry into A_GREEN or B_GREEN, 0 otherwise. It is 0 in the first cycle after reset release.
- Sensor changes during yellow are ignored. Sensors are sampled only in green states and are not latched.

Optional Feature:
- Macro: TL_ALL_RED_EN.
- When defined: a CLEAR state is inserted after each yellow.
  - In CLEAR, La=Lb=10 for exactly ALL_RED_TIME cycles, then the next green.
  - phase keeps showing the preceding yellow code during CLEAR.
  - An internal 1-bit dir register selects the next green (A or B).
- When undefined: yellow goes directly to the opposite green, and no CLEAR or dir logic is synthesised.

Decomposition:
- Shared package tl_pkg:
  - State encodings S_A_GREEN=2'b00, S_A_YELLOW=2'b01, S_B_GREEN=2'b10, S_B_YELLOW=2'b11.
  - Lamp codes L_GREEN=2'b00, L_YELLOW=2'b01, L_RED=2'b10.
- One sub-module, tl_phase_timer: a saturating cycle counter with synchronous clear and async reset, parameterised by width and saturation value.
- Next-state and lamp decode stay inline in tl_sched_cntr.

Test Plan:
All scenarios use MIN_GREEN=4, MAX_GREEN=8, YELLOW_TIME=2.
1. Reset, then Ta=1, Tb=0 for 20 cycles -> phase stays 00, La=00, Lb=10 throughout.
2. Ta=0, Tb=1 from reset release -> A_GREEN for 4 cycles, A_YELLOW for 2 cycles, B_GREEN from cycle 6; switch_pulse=1 only in cycle 6.
3. Ta=1, Tb=1 held -> phase sequence is 00 for 8 cycles, 01 for 2, 10 for 8, 11 for 2, repeating with period 20.
4. Assert reset for 1 ns mid-A_YELLOW (between clock edges) -> La=00, Lb=10, phase=00 immediately; after release, A_GREEN again lasts at least 4 cycles.
5. Ta=0, Tb=0 held -> continuous rotation of 4/2/4/2 cycles; La and Lb are never both non-red in any cycle (checked by assertion).
6. With TL_ALL_RED_EN and ALL_RED_TIME=1, Ta=0, Tb=1 -> after 2 yellow cycles, one cycle of La=Lb=10 with phase=01, then B_GREEN.
